vec_host_ctrl: RTL and testbench

//  Hardware host sequencer for an array of VecCore instances: loads per-core inst/data memory from one

---
 rtl/vec_host_pkg.sv | 33 +++
 rtl/vec_host_dump_fifo.sv | 42 ++++
 rtl/vec_host_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_vec_host_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_host_pkg.sv
// Shared types and default widths for the vec core host sequencer.
package vec_host_pkg;

  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_WORD_W    = 32;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_TIMEOUT_W = 24;

  // Fixed encodings kept identical to the legacy controller.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD_INST = 3'd1;
  localparam logic [2:0] ST_LOAD_DATA = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_DUMP      = 3'd5;
  localparam logic [2:0] ST_FIN       = 3'd6;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    LOAD_INST = ST_LOAD_INST,
    LOAD_DATA = ST_LOAD_DATA,
    RUN       = ST_RUN,
    WAIT_DONE = ST_WAIT_DONE,
    DUMP      = ST_DUMP,
    FIN       = ST_FIN
  } state_t;

  typedef enum logic {
    MEM_INST = 1'b0,
    MEM_DATA = 1'b1
  } mem_sel_t;

endpackage

// File: rtl/vec_host_dump_fifo.sv
// Two-entry output FIFO for dumped words; count lets the caller budget reads.
module vec_host_dump_fifo #(
  parameter int WORD_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [1:0]        count
);

  logic [WORD_W-1:0] store [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic              pop;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = store[rd_ptr];

  // Pointer and occupancy tracking.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // Word storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clock) begin
    if (push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vec_host_ctrl.sv
// Host sequencer for the vec core array: load inst/data memories from the
// input stream, release core resets, wait for done, dump data memories.
// Optional watchdog: define VEC_HOST_TIMEOUT_EN.
module vec_host_ctrl
  import vec_host_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int WORD_W    = DEF_WORD_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int TIMEOUT_W = DEF_TIMEOUT_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NUM_CORES-1:0]        core_mask,
  input  logic [ADDR_W:0]             inst_len,
  input  logic [ADDR_W:0]             data_len,
  input  logic [ADDR_W:0]             dump_len,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W-1:0]           in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W-1:0]           out_data,
  output logic [NUM_CORES-1:0]        mem_we,
  output logic [NUM_CORES-1:0]        mem_re,
  output logic                        mem_sel,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [WORD_W-1:0]           mem_wdata,
  input  logic [NUM_CORES*WORD_W-1:0] mem_rdata,
  output logic [NUM_CORES-1:0]        core_reset,
  input  logic [NUM_CORES-1:0]        core_done,
  output logic                        busy,
  output logic                        finished,
  output logic                        timeout
);

  localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

  // {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [CORE_W:0] find_core(input logic [NUM_CORES-1:0] m,
                                                input int unsigned from);
    logic [CORE_W:0] r;
    r = '0;
    for (int unsigned i = NUM_CORES; i > 0; i--) begin
      if ((i - 1) >= from && m[i-1]) r = {1'b1, CORE_W'(i - 1)};
    end
    return r;
  endfunction

  function automatic logic [ADDR_W:0] sat_len(input logic [ADDR_W:0] l);
    return (l[ADDR_W] && (|l[ADDR_W-1:0])) ? LEN_MAX : l;
  endfunction

  state_t                state;
  logic [NUM_CORES-1:0]  mask_q;
  logic [NUM_CORES-1:0]  flags;
  logic [ADDR_W:0]       inst_len_q, data_len_q, dump_len_q;
  logic [ADDR_W-1:0]     addr;
  logic [CORE_W-1:0]     ptr;
  logic [CORE_W-1:0]     rd_core;
  logic                  reads_done;
  logic                  pend;
  logic [CORE_W:0]       first_start, first_run, next_core;
  logic [ADDR_W:0]       sec_len;
  logic                  load, wr, re, sec_last, dump_last, pop;
  logic [1:0]            fifo_count;
  logic [2:0]            occ;
  logic [NUM_CORES-1:0]  cur_onehot;

  assign first_start = find_core(core_mask, 0);
  assign first_run   = find_core(mask_q, 0);
  assign next_core   = find_core(mask_q, 32'(ptr) + 32'd1);

  assign load       = (state == LOAD_INST) || (state == LOAD_DATA);
  assign sec_len    = (state == LOAD_INST) ? inst_len_q : data_len_q;
  assign sec_last   = ({1'b0, addr} == sec_len - (ADDR_W+1)'(1));
  assign dump_last  = ({1'b0, addr} == dump_len_q - (ADDR_W+1)'(1));
  assign cur_onehot = NUM_CORES'(1) << ptr;

  assign in_ready = load && (sec_len != '0);
  assign wr       = in_valid && in_ready;

  // Read credit: FIFO slots minus words already committed, counting the one
  // leaving this cycle, so a captured read word always finds a free slot.
  assign pop = out_valid && out_ready;
  assign occ = 3'(fifo_count) + 3'(pend) - 3'(pop);
  assign re  = (state == DUMP) && !reads_done && (dump_len_q != '0) && (occ < 3'd2);

  assign mem_we     = wr ? cur_onehot : '0;
  assign mem_re     = re ? cur_onehot : '0;
  assign mem_sel    = (state == LOAD_INST) ? MEM_INST : MEM_DATA;
  assign mem_addr   = addr;
  assign mem_wdata  = in_data;
  assign core_reset = (state == RUN || state == WAIT_DONE || state == DUMP) ? ~mask_q : '1;
  assign busy       = (state != IDLE) && (state != FIN);

`ifdef VEC_HOST_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic [TIMEOUT_W-1:0] wd_next;
  logic                 timeout_q;
  assign wd_next = wd_cnt + TIMEOUT_W'(1);
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  vec_host_dump_fifo #(.WORD_W(WORD_W)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (pend),
    .push_data (mem_rdata[int'(rd_core)*WORD_W +: WORD_W]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (fifo_count)
  );

  // Job sequencing: load, run, wait, dump, finish.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mask_q     <= '0;
      flags      <= '0;
      inst_len_q <= '0;
      data_len_q <= '0;
      dump_len_q <= '0;
      addr       <= '0;
      ptr        <= '0;
      rd_core    <= '0;
      reads_done <= 1'b0;
      pend       <= 1'b0;
      finished   <= 1'b0;
`ifdef VEC_HOST_TIMEOUT_EN
      wd_cnt     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      finished <= 1'b0;
      pend     <= re;
      if (re) rd_core <= ptr;
      case (state)
        IDLE: if (start) begin
`ifdef VEC_HOST_TIMEOUT_EN
          timeout_q <= 1'b0;
`endif
          if (!first_start[CORE_W]) begin
            state <= FIN;
          end else begin
            mask_q     <= core_mask;
            inst_len_q <= sat_len(inst_len);
            data_len_q <= sat_len(data_len);
            dump_len_q <= sat_len(dump_len);
            ptr        <= first_start[CORE_W-1:0];
            addr       <= '0;
            state      <= LOAD_INST;
          end
        end
        LOAD_INST: begin
          if (inst_len_q == '0 || (wr && sec_last)) begin
            addr  <= '0;
            state <= LOAD_DATA;
          end else if (wr) begin
            addr <= addr + ADDR_W'(1);
          end
        end
        LOAD_DATA: begin
          if (data_len_q == '0 || (wr && sec_last)) begin
            addr <= '0;
            if (next_core[CORE_W]) begin
              ptr   <= next_core[CORE_W-1:0];
              state <= LOAD_INST;
            end else begin
              state <= RUN;
            end
          end else if (wr) begin
            addr <= addr + ADDR_W'(1);
          end
        end
        RUN: begin
          flags      <= '0;
          addr       <= '0;
          reads_done <= 1'b0;
          if (first_run[CORE_W]) ptr <= first_run[CORE_W-1:0];
`ifdef VEC_HOST_TIMEOUT_EN
          wd_cnt     <= '0;
`endif
          state      <= WAIT_DONE;
        end
        WAIT_DONE: begin
          flags <= flags | core_done;
          if ((flags & mask_q) == mask_q) state <= DUMP;
`ifdef VEC_HOST_TIMEOUT_EN
          else if (wd_next == '1) begin
            timeout_q <= 1'b1;
            state     <= FIN;
          end
          wd_cnt <= wd_next;
`endif
        end
        DUMP: begin
          if (!reads_done && (dump_len_q == '0 || (re && dump_last))) begin
            addr <= '0;
            if (next_core[CORE_W]) ptr <= next_core[CORE_W-1:0];
            else                   reads_done <= 1'b1;
          end else if (re) begin
            addr <= addr + ADDR_W'(1);
          end
          if (reads_done && !pend && (fifo_count == 2'd0 || (fifo_count == 2'd1 && pop)))
            state <= FIN;
        end
        FIN: begin
          finished <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_host_ctrl.sv
// Directed bench for vec_host_ctrl: load/run/dump jobs, empty mask,
// mid-job reset, length saturation and (with VEC_HOST_TIMEOUT_EN) watchdog.
`timescale 1ns/1ps
module tb_vec_host_ctrl;

  localparam int NC = 4;
  localparam int WW = 32;
  localparam int AW = 4;
`ifdef VEC_HOST_TIMEOUT_EN
  localparam int TW = 4;
`else
  localparam int TW = 24;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [NC-1:0]    core_mask = '0;
  logic [AW:0]      inst_len = '0, data_len = '0, dump_len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WW-1:0]    in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WW-1:0]    out_data;
  logic [NC-1:0]    mem_we, mem_re;
  logic             mem_sel;
  logic [AW-1:0]    mem_addr;
  logic [WW-1:0]    mem_wdata;
  logic [NC*WW-1:0] mem_rdata = '0;
  logic [NC-1:0]    core_reset;
  logic [NC-1:0]    core_done = '0;
  logic             busy, finished, timeout;

  int ntests = 0;
  int nfail  = 0;

  // Monitor state
  int nw = 0, nre = 0, nfin = 0, nbusy = 0, nov = 0, nbadsel = 0, nbadcore = 0;
  logic [NC-1:0] wl_we   [64];
  logic          wl_sel  [64];
  logic [AW-1:0] wl_addr [64];
  logic [WW-1:0] wl_data [64];
  logic [WW-1:0] outs    [32];
  int got = 0;

  vec_host_ctrl #(.NUM_CORES(NC), .WORD_W(WW), .ADDR_W(AW), .TIMEOUT_W(TW)) dut (
    .clock(clock), .reset(reset), .start(start), .core_mask(core_mask),
    .inst_len(inst_len), .data_len(data_len), .dump_len(dump_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mem_we(mem_we), .mem_re(mem_re), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .core_reset(core_reset),
    .core_done(core_done), .busy(busy), .finished(finished), .timeout(timeout)
  );

  always #5 clock = ~clock;

  // Core memory model: read word = addr + 100 + 1000*core, one cycle late.
  always @(posedge clock) begin
    if (mem_we != '0) begin
      if (nw < 64) begin
        wl_we[nw] = mem_we; wl_sel[nw] = mem_sel;
        wl_addr[nw] = mem_addr; wl_data[nw] = mem_wdata;
      end
      nw++;
    end
    if (mem_re != '0) begin
      nre++;
      if (mem_sel !== 1'b1) nbadsel++;
    end
    if (((mem_we | mem_re) & 4'b1010) != '0) nbadcore++;
    if (finished) nfin++;
    if (busy) nbusy++;
    if (out_valid) nov++;
    for (int i = 0; i < NC; i++)
      if (mem_re[i]) mem_rdata[i*WW +: WW] <= 32'(mem_addr) + 32'd100 + 32'(1000 * i);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_write(input int i, input logic [3:0] we, input logic sel,
                             input logic [3:0] a, input logic [31:0] d);
    check($sformatf("wr%0d_we", i),   32'(wl_we[i]),   32'(we));
    check($sformatf("wr%0d_sel", i),  32'(wl_sel[i]),  32'(sel));
    check($sformatf("wr%0d_addr", i), 32'(wl_addr[i]), 32'(a));
    check($sformatf("wr%0d_data", i), wl_data[i],      d);
  endtask

  // Called at a negedge; lengths/mask are scrambled afterwards to prove latching.
  task automatic start_job(input logic [3:0] m, input int il, input int dl, input int ul);
    core_mask = m; inst_len = 5'(il); data_len = 5'(dl); dump_len = 5'(ul);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    core_mask = 4'b1111; inst_len = 5'd7; data_len = 5'd7; dump_len = 5'd7;
  endtask

  task automatic feed(input int n, input logic [31:0] base);
    int k = 0;
    int guard = 0;
    bit hs;
    while (k < n && guard < 200) begin
      in_valid = (guard % 4) != 3;
      in_data  = base + 32'(k);
      hs = in_valid && in_ready;
      @(posedge clock);
      if (hs) k++;
      @(negedge clock);
      guard++;
    end
    in_valid = 1'b0;
    check("feed_done", 32'(k), 32'(n));
  endtask

  task automatic dump_collect(input bit toggle);
    int fin0 = nfin;
    int cyc = 0;
    bit tog = 1'b1;
    got = 0;
    while (nfin == fin0 && cyc < 400) begin
      out_ready = toggle ? tog : 1'b1;
      tog = ~tog;
      if (out_valid && out_ready) begin
        if (got < 32) outs[got] = out_data;
        got++;
      end
      @(negedge clock);
      cyc++;
    end
    out_ready = 1'b0;
    check("finish_seen", 32'(nfin - fin0), 32'd1);
  endtask

  initial begin
    int w0, r0, b0, f0, o0, cyc;

    // Reset values
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_re", 32'(mem_re), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_finished", 32'(finished), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_core_reset", 32'(core_reset), 32'hF);
    reset = 1'b0;
    @(negedge clock);

    // Job A: mask 0101, inst 2, data 3, dump 4; done[0] already high
    core_done = 4'b0001;
    w0 = nw; r0 = nre;
    start_job(4'b0101, 2, 3, 4);
    check("a_busy", 32'(busy), 1);
    feed(10, 32'hA000);
    check("a_nwrites", 32'(nw - w0), 10);
    check_write(w0 + 0, 4'b0001, 1'b0, 4'd0, 32'hA000);
    check_write(w0 + 1, 4'b0001, 1'b0, 4'd1, 32'hA001);
    check_write(w0 + 2, 4'b0001, 1'b1, 4'd0, 32'hA002);
    check_write(w0 + 3, 4'b0001, 1'b1, 4'd1, 32'hA003);
    check_write(w0 + 4, 4'b0001, 1'b1, 4'd2, 32'hA004);
    check_write(w0 + 5, 4'b0100, 1'b0, 4'd0, 32'hA005);
    check_write(w0 + 6, 4'b0100, 1'b0, 4'd1, 32'hA006);
    check_write(w0 + 7, 4'b0100, 1'b1, 4'd0, 32'hA007);
    check_write(w0 + 8, 4'b0100, 1'b1, 4'd1, 32'hA008);
    check_write(w0 + 9, 4'b0100, 1'b1, 4'd2, 32'hA009);
    check("a_core_reset_run", 32'(core_reset), 32'b1010);
    repeat (50) @(negedge clock);
    check("a_core_reset_wait", 32'(core_reset), 32'b1010);
    check("a_no_early_dump", 32'(nre - r0), 0);
    check("a_no_early_out", 32'(out_valid), 0);
    core_done = 4'b0101;
    dump_collect(1'b1);
    check("a_nout", 32'(got), 8);
    check("a_out0", outs[0], 32'd100);
    check("a_out1", outs[1], 32'd101);
    check("a_out2", outs[2], 32'd102);
    check("a_out3", outs[3], 32'd103);
    check("a_out4", outs[4], 32'd2100);
    check("a_out5", outs[5], 32'd2101);
    check("a_out6", outs[6], 32'd2102);
    check("a_out7", outs[7], 32'd2103);
    check("a_nreads", 32'(nre - r0), 8);
    check("a_read_sel", 32'(nbadsel), 0);
    check("a_unmasked_quiet", 32'(nbadcore), 0);
    check("a_busy_end", 32'(busy), 0);
    check("a_core_reset_end", 32'(core_reset), 32'hF);
    check("a_timeout", 32'(timeout), 0);

    // Empty mask: finished two cycles after start, no traffic, never busy
    core_done = '0;
    w0 = nw; r0 = nre; b0 = nbusy; f0 = nfin;
    start_job(4'b0000, 3, 3, 3);
    check("e_fin_early", 32'(finished), 0);
    @(negedge clock);
    check("e_fin_pulse", 32'(finished), 1);
    @(negedge clock);
    check("e_fin_once", 32'(finished), 0);
    check("e_nfin", 32'(nfin - f0), 1);
    check("e_no_busy", 32'(nbusy - b0), 0);
    check("e_no_traffic", 32'((nw - w0) + (nre - r0)), 0);

    // Reset during LOAD_DATA
    w0 = nw;
    start_job(4'b0001, 1, 4, 2);
    feed(3, 32'hB000);
    in_valid = 1'b1; in_data = 32'hBEEF;
    reset = 1'b1;
    #1;
    check("r_mem_we", 32'(mem_we), 0);
    check("r_core_reset", 32'(core_reset), 32'hF);
    check("r_in_ready", 32'(in_ready), 0);
    check("r_busy", 32'(busy), 0);
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    check("r_nwrites", 32'(nw - w0), 3);

    // Job after reset: core1 only, done high before start
    core_done = 4'b0010;
    w0 = nw;
    start_job(4'b0010, 1, 1, 2);
    feed(2, 32'hC000);
    check("c_nwrites", 32'(nw - w0), 2);
    check_write(w0 + 0, 4'b0010, 1'b0, 4'd0, 32'hC000);
    check_write(w0 + 1, 4'b0010, 1'b1, 4'd0, 32'hC001);
    dump_collect(1'b0);
    check("c_nout", 32'(got), 2);
    check("c_out0", outs[0], 32'd1100);
    check("c_out1", outs[1], 32'd1101);

    // Saturation: dump_len 31 clamps to 16 with ADDR_W=4; empty inst section
    core_done = 4'b1000;
    w0 = nw;
    start_job(4'b1000, 0, 1, 31);
    feed(1, 32'hD000);
    check("s_nwrites", 32'(nw - w0), 1);
    check_write(w0, 4'b1000, 1'b1, 4'd0, 32'hD000);
    dump_collect(1'b1);
    check("s_nout", 32'(got), 16);
    for (int k = 0; k < 16; k++)
      check($sformatf("s_out%0d", k), outs[k], 32'd3100 + 32'(k));

`ifdef VEC_HOST_TIMEOUT_EN
    // Watchdog: done never rises
    core_done = '0;
    o0 = nov; f0 = nfin;
    start_job(4'b0001, 0, 0, 1);
    cyc = 0;
    while (core_reset !== 4'b1110 && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    check("t_run_seen", 32'(core_reset), 32'b1110);
    repeat (15) @(negedge clock);
    check("t_not_yet", 32'(timeout), 0);
    @(negedge clock);
    check("t_set", 32'(timeout), 1);
    repeat (4) @(negedge clock);
    check("t_sticky", 32'(timeout), 1);
    check("t_nfin", 32'(nfin - f0), 1);
    check("t_no_out", 32'(nov - o0), 0);
`else
    o0 = 0; f0 = 0; cyc = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
